// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: two-requester round-robin bus cycle engine (T1-T4).
// Define BUS_WAIT_EN to add the READY input and the TW wait state.
module bus_cycle_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [1:0]             req,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  input  logic [1:0]             req_wr,
  input  logic [1:0]             req_io,
`ifdef BUS_WAIT_EN
  input  logic                   READY,
`endif
  output logic [1:0]             gnt,
  output logic [1:0]             done,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ALE,
  output logic                   RD,
  output logic                   WR,
  output logic                   IO_M,
  output logic [ADDR_W-1:0]      ADDR,
  inout  wire  [DATA_W-1:0]      DATA,
  output logic                   CS_MEM0,
  output logic                   CS_MEM1,
  output logic                   CS_IO
);

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    T3   = 6'b001000,
`ifdef BUS_WAIT_EN
    TW   = 6'b010000,
`endif
    T4   = 6'b100000
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [1:0]          own_q;
  logic                last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                wr_q;
  logic                io_q;
  logic [1:0]          pick;
  logic                ale;
  logic                strb;
  logic                fin;
  logic                cap;
  logic                busy;

  // Round-robin pick: on a tie the requester not served last wins
  always_comb begin
    pick = 2'b00;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_q ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and per-phase strobes
  always_comb begin
    state_n = state;
    ale     = 1'b0;
    strb    = 1'b0;
    fin     = 1'b0;
    cap     = 1'b0;
    unique case (state)
      IDLE: if (|req) state_n = T1;
      T1: begin
        ale     = 1'b1;
        state_n = T2;
      end
      T2: begin
        strb    = 1'b1;
        state_n = T3;
      end
`ifdef BUS_WAIT_EN
      T3, TW: begin
        strb = 1'b1;
        if (READY) begin
          cap     = 1'b1;
          state_n = T4;
        end else begin
          state_n = TW;
        end
      end
`else
      T3: begin
        strb    = 1'b1;
        cap     = 1'b1;
        state_n = T4;
      end
`endif
      T4: begin
        fin     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Latch owner attributes at grant; read data on the edge into T4
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      own_q   <= 2'b00;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && |req) begin
        own_q   <= pick;
        last_q  <= pick[1];
        addr_q  <= req_addr[pick[1]];
        wdata_q <= req_wdata[pick[1]];
        wr_q    <= req_wr[pick[1]];
        io_q    <= req_io[pick[1]];
      end
      if (cap && !wr_q) rdata_q <= DATA;
    end
  end

  assign busy    = (state != IDLE);
  assign gnt     = busy ? own_q : 2'b00;
  assign done    = fin ? own_q : 2'b00;
  assign ALE     = ale;
  assign RD      = ~(strb & ~wr_q);
  assign WR      = ~(strb & wr_q);
  assign DATA    = (strb & wr_q) ? wdata_q : {DATA_W{1'bz}};
  assign IO_M    = busy & io_q;
  assign CS_IO   = busy & io_q;
  assign CS_MEM0 = busy & ~io_q & ~addr_q[ADDR_W-1];
  assign CS_MEM1 = busy & ~io_q & addr_q[ADDR_W-1];
  assign ADDR    = addr_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// tb_bus_cycle_arbiter: directed and random bus cycles checked against
// a transaction-level model with a banked peripheral memory on the bus.
module tb_bus_cycle_arbiter;
  localparam int AW = 20;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][DW-1:0] req_wdata;
  logic [1:0] req_wr;
  logic [1:0] req_io;
`ifdef BUS_WAIT_EN
  logic ready;
`endif
  logic [1:0] gnt;
  logic [1:0] done;
  logic [DW-1:0] rdata;
  logic ale, rd_n, wr_n, io_m;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data;
  logic cs_mem0, cs_mem1, cs_io;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_cycle_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(clk),
    .RESET(rst_n),
    .req(req),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wr(req_wr),
    .req_io(req_io),
`ifdef BUS_WAIT_EN
    .READY(ready),
`endif
    .gnt(gnt),
    .done(done),
    .rdata(rdata),
    .ALE(ale),
    .RD(rd_n),
    .WR(wr_n),
    .IO_M(io_m),
    .ADDR(addr),
    .DATA(data),
    .CS_MEM0(cs_mem0),
    .CS_MEM1(cs_mem1),
    .CS_IO(cs_io)
  );

  function automatic logic [7:0] init_val(int i);
    if (i == 16) return 8'h5A;
    return 8'(i * 7 + 1);
  endfunction

  // Peripheral: 512 bytes indexed by space, bank and low address bits
  logic [7:0] pmem [512];
  logic [8:0] pidx;
  assign pidx = {io_m, addr[AW-1], addr[6:0]};
  assign data = !rd_n ? pmem[pidx] : 'z;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) pmem[i] <= init_val(i);
    end else if (!wr_n) begin
      pmem[pidx] <= data;
    end
  end

  // Transaction model: phase 0 idle, 1..4 = T1..T4, 5 = wait
  int m_ph, m_own, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rdata;
  logic m_wr, m_io;
  logic [7:0] ref_mem [512];

  task automatic model_edge();
    logic rdy;
    int idx;
    rdy = 1'b1;
`ifdef BUS_WAIT_EN
    rdy = ready;
`endif
    if (!rst_n) begin
      m_ph = 0; m_own = 0; m_last = 1;
      m_rdata = '0; m_addr = '0; m_wd = '0;
      m_wr = 1'b0; m_io = 1'b0;
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    end else begin
      idx = {m_io, m_addr[AW-1], m_addr[6:0]};
      case (m_ph)
        0: if (req != 2'b00) begin
          if (req == 2'b11) m_own = 1 - m_last;
          else m_own = req[1] ? 1 : 0;
          m_last = m_own;
          m_addr = req_addr[m_own];
          m_wd = req_wdata[m_own];
          m_wr = req_wr[m_own];
          m_io = req_io[m_own];
          m_ph = 1;
        end
        1: m_ph = 2;
        2: m_ph = 3;
        3, 5: if (rdy) begin
          if (!m_wr) m_rdata = ref_mem[idx];
          m_ph = 4;
        end else begin
          m_ph = 5;
        end
        default: begin
          if (m_wr) ref_mem[idx] = m_wd;
          m_ph = 0;
        end
      endcase
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic get_vec(output logic [38:0] act,
                         output logic [38:0] exp);
    logic busy, strb;
    logic [1:0] og;
    busy = (m_ph != 0);
    strb = (m_ph == 2 || m_ph == 3 || m_ph == 5);
    og = !busy ? 2'b00 : (m_own == 1 ? 2'b10 : 2'b01);
    act = {gnt, done, ale, rd_n, wr_n, io_m,
           cs_mem0, cs_mem1, cs_io, addr, rdata};
    exp = {og, (m_ph == 4) ? og : 2'b00, m_ph == 1,
           !(strb && !m_wr), !(strb && m_wr), busy && m_io,
           busy && !m_io && !m_addr[AW-1],
           busy && !m_io && m_addr[AW-1],
           busy && m_io, m_addr, m_rdata};
  endtask

  task automatic set_req(int r, logic [AW-1:0] a, logic [DW-1:0] d,
                         logic w, logic io);
    req_addr[r] = a;
    req_wdata[r] = d;
    req_wr[r] = w;
    req_io[r] = io;
    req[r] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b00;
    req_addr = '0; req_wdata = '0; req_wr = '0; req_io = '0;
`ifdef BUS_WAIT_EN
    ready = 1'b1;
`endif
    step();
    step();
    checks++;
    if (gnt !== 2'b00 || done !== 2'b00) begin
      failures++;
      $display("FAIL reset_gnt_done act=%b/%b exp=00/00", gnt, done);
    end
    checks++;
    if (rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_rdata act=%h exp=00", rdata);
    end
    checks++;
    if ({ale, rd_n, wr_n, io_m} !== 4'b0110) begin
      failures++;
      $display("FAIL reset_ctl act=%b exp=0110",
               {ale, rd_n, wr_n, io_m});
    end
    checks++;
    if (addr !== '0 || {cs_mem0, cs_mem1, cs_io} !== 3'b000) begin
      failures++;
      $display("FAIL reset_addr_cs act=%h/%b exp=0/000",
               addr, {cs_mem0, cs_mem1, cs_io});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 2'b00 || ale !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle act=%b/%b exp=00/0", gnt, ale);
    end
  endtask

  task automatic test_single_read();
    logic [38:0] a, e;
    set_req(0, 20'h00010, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      get_vec(a, e);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL read_cyc%0d act=%h exp=%h", k, a, e);
      end
      if (k == 1) begin
        checks++;
        if ({ale, gnt, cs_mem0} !== 4'b1011) begin
          failures++;
          $display("FAIL read_t1 act=%b exp=1011",
                   {ale, gnt, cs_mem0});
        end
      end
      if (k == 2 || k == 3) begin
        checks++;
        if ({rd_n, wr_n} !== 2'b01) begin
          failures++;
          $display("FAIL read_strobe%0d act=%b exp=01",
                   k, {rd_n, wr_n});
        end
      end
      if (k == 4) begin
        checks++;
        if (done !== 2'b01 || rdata !== 8'h5A) begin
          failures++;
          $display("FAIL read_done act=%b/%h exp=01/5a", done, rdata);
        end
        req[0] = 1'b0;
      end
    end
  endtask

  task automatic test_single_write();
    logic [38:0] a, e;
    set_req(1, 20'h80004, 8'hC3, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      get_vec(a, e);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL write_cyc%0d act=%h exp=%h", k, a, e);
      end
      if (k == 1) begin
        checks++;
        if ({cs_mem0, cs_mem1, cs_io} !== 3'b010) begin
          failures++;
          $display("FAIL write_cs act=%b exp=010",
                   {cs_mem0, cs_mem1, cs_io});
        end
      end
      if (k == 2 || k == 3) begin
        checks++;
        if (wr_n !== 1'b0 || rd_n !== 1'b1 || data !== 8'hC3) begin
          failures++;
          $display("FAIL write_drive%0d act=%b%b/%h exp=10/c3",
                   k, rd_n, wr_n, data);
        end
      end
      if (k == 4) begin
        checks++;
        if (done !== 2'b10 || pmem[132] !== 8'hC3) begin
          failures++;
          $display("FAIL write_done act=%b/%h exp=10/c3",
                   done, pmem[132]);
        end
        req[1] = 1'b0;
      end
    end
    set_req(0, 20'h80004, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) begin
        checks++;
        if (done !== 2'b01 || rdata !== 8'hC3) begin
          failures++;
          $display("FAIL write_readback act=%b/%h exp=01/c3",
                   done, rdata);
        end
        req[0] = 1'b0;
      end
    end
  endtask

  task automatic test_io();
    logic [38:0] a, e;
    set_req(0, 20'h00060, 8'h00, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      get_vec(a, e);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL io_cyc%0d act=%h exp=%h", k, a, e);
      end
      if (k <= 4) begin
        checks++;
        if ({io_m, cs_io, cs_mem0, cs_mem1} !== 4'b1100) begin
          failures++;
          $display("FAIL io_sel%0d act=%b exp=1100",
                   k, {io_m, cs_io, cs_mem0, cs_mem1});
        end
      end
      if (k == 4) req[0] = 1'b0;
    end
  endtask

  task automatic test_contention();
    logic [38:0] a, e;
    logic [1:0] exp_g;
    int n, idle_run, seen;
    n = 0; idle_run = 0; seen = 0;
    rst_n = 1'b0;
    req = 2'b00;
    step();
    rst_n = 1'b1;
    set_req(0, 20'h00021, 8'h11, 1'b0, 1'b0);
    set_req(1, 20'h80022, 8'h22, 1'b1, 1'b0);
    for (int k = 0; k < 40 && seen < 4; k++) begin
      step();
      get_vec(a, e);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cont_cyc%0d act=%h exp=%h", k, a, e);
      end
      checks++;
      if ($countones(gnt) > 1) begin
        failures++;
        $display("FAIL cont_overlap act=%b exp=onehot0", gnt);
      end
      if (ale) begin
        exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (gnt !== exp_g) begin
          failures++;
          $display("FAIL cont_order%0d act=%b exp=%b", n, gnt, exp_g);
        end
        if (n > 0) begin
          checks++;
          if (idle_run != 1) begin
            failures++;
            $display("FAIL cont_gap%0d act=%0d exp=1", n, idle_run);
          end
        end
        n++;
      end
      if (gnt == 2'b00) idle_run++;
      else idle_run = 0;
      if (done != 2'b00) seen++;
    end
    req = 2'b00;
    checks++;
    if (seen != 4) begin
      failures++;
      $display("FAIL cont_timeout act=%0d exp=4", seen);
    end
    step();
  endtask

  task automatic test_reset_mid_write();
    logic [38:0] a, e;
    set_req(1, 20'h80010, 8'h77, 1'b1, 1'b0);
    step();
    step();
    checks++;
    if (wr_n !== 1'b0 || data !== 8'h77) begin
      failures++;
      $display("FAIL rmw_t2 act=%b/%h exp=0/77", wr_n, data);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({gnt, done, ale, wr_n, rd_n} !== 7'b0000011) begin
      failures++;
      $display("FAIL rmw_idle act=%b exp=0000011",
               {gnt, done, ale, wr_n, rd_n});
    end
    rst_n = 1'b1;
    req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step();
      get_vec(a, e);
      checks++;
      if (a !== e || done !== 2'b00) begin
        failures++;
        $display("FAIL rmw_after%0d act=%h exp=%h", k, a, e);
      end
    end
  endtask

`ifdef BUS_WAIT_EN
  task automatic test_wait();
    logic [38:0] a, e;
    ready = 1'b1;
    set_req(0, 20'h00010, 8'h00, 1'b0, 1'b0);
    step();
    step();
    ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      get_vec(a, e);
      checks++;
      if (rd_n !== 1'b0 || done !== 2'b00 || a !== e) begin
        failures++;
        $display("FAIL wait_tw%0d act=%b/%b exp=0/00", k, rd_n, done);
      end
    end
    ready = 1'b1;
    step();
    checks++;
    if (done !== 2'b01 || rdata !== 8'h5A) begin
      failures++;
      $display("FAIL wait_done act=%b/%h exp=01/5a", done, rdata);
    end
    req = 2'b00;
    step();
  endtask
`endif

  task automatic test_random();
    logic [38:0] a, e;
    rst_n = 1'b0;
    req = 2'b00;
    step();
    for (int s = 0; s < 800; s++) begin
      rst_n = ($urandom_range(0, 199) != 0);
`ifdef BUS_WAIT_EN
      ready = ($urandom_range(0, 2) != 0);
`endif
      step();
      get_vec(a, e);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL rand_cyc%0d act=%h exp=%h", s, a, e);
      end
      if (m_wr && (m_ph == 2 || m_ph == 3 || m_ph == 5)) begin
        checks++;
        if (data !== m_wd) begin
          failures++;
          $display("FAIL rand_data%0d act=%h exp=%h", s, data, m_wd);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (req[r] && m_ph == 4 && m_own == r) begin
          req[r] = 1'b0;
        end else if (!req[r] && $urandom_range(0, 3) == 0) begin
          set_req(r, {1'($urandom), 12'h000, 7'($urandom)},
                  8'($urandom), 1'($urandom), 1'($urandom));
        end
      end
    end
    req = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_io();
    test_contention();
    test_reset_mid_write();
`ifdef BUS_WAIT_EN
    test_wait();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
